// File: rtl/perf_counter_bank.sv
// perf_counter_bank: cycle counter plus programmable event counters behind a word-register
// MMIO port, with shadowed hi-word reads, sticky overflow flags and a maskable interrupt.
module perf_counter_bank #(
   parameter int NUM_CNTR = 8,
   parameter int CNTR_W   = 64,
   parameter int NUM_EVT  = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_EVT-1:0] evt_i,
   input  logic               halt_i,
   input  logic               req_i,
   input  logic               we_i,
   input  logic [5:0]         addr_i,
   input  logic [31:0]        wdata_i,
   output logic [31:0]        rdata_o,
   output logic               rvalid_o,
   output logic               irq_o
);
   localparam int HI_W = CNTR_W - 32;

   logic [CNTR_W-1:0]   cntr     [NUM_CNTR];
   logic [CNTR_W-1:0]   cntr_nxt [NUM_CNTR];
   logic [3:0]          evtsel   [NUM_CNTR];
   logic [NUM_CNTR-1:0] inc, ovf, ovf_set, ovf_nxt, mask;
   logic [HI_W-1:0]     shadow, shadow_nxt;
   logic [31:0]         rdata_nxt;
   logic [15:0]         evt_pad;
   logic                en, rd, wr, clr_all;

   assign rd      = req_i & ~we_i;
   assign wr      = req_i & we_i;
   assign clr_all = wr && addr_i == 6'h00 && wdata_i[1];
   // Zero-padded so any 4-bit select can index safely; selects >= NUM_EVT are also masked below.
   assign evt_pad = 16'(evt_i);

   always_comb begin
      inc = '0;
      for (int unsigned k = 0; k < NUM_CNTR; k++) begin
         if (k == 0) inc[k] = 1'b1;
         else        inc[k] = (int'(evtsel[k]) < NUM_EVT) && evt_pad[evtsel[k]];
      end
      if (!en || halt_i) inc = '0;
   end

   always_comb begin
      ovf_set = '0;
      for (int unsigned k = 0; k < NUM_CNTR; k++) begin
         cntr_nxt[k] = cntr[k];
         if (clr_all) begin
            cntr_nxt[k] = '0;
         end else if (wr && addr_i == 6'(16 + 2 * k)) begin
            cntr_nxt[k][31:0] = wdata_i;
         end else if (wr && addr_i == 6'(17 + 2 * k)) begin
            cntr_nxt[k][CNTR_W-1:32] = wdata_i[HI_W-1:0];
         end else if (inc[k]) begin
            cntr_nxt[k] = cntr[k] + 1'b1;
            ovf_set[k]  = &cntr[k];
         end
      end
   end

   // Hardware overflow wins over a same-cycle write-1-to-clear.
   always_comb begin
      ovf_nxt = ovf | ovf_set;
      if (wr && addr_i == 6'h01) ovf_nxt = (ovf & ~wdata_i[NUM_CNTR-1:0]) | ovf_set;
   end

   always_comb begin
      rdata_nxt  = '0;
      shadow_nxt = shadow;
      if (rd) begin
         if (addr_i == 6'h00) rdata_nxt = {31'b0, en};
         if (addr_i == 6'h01) rdata_nxt = 32'(ovf);
         if (addr_i == 6'h02) rdata_nxt = 32'(mask);
         for (int unsigned k = 0; k < NUM_CNTR; k++) begin
            if (addr_i == 6'(16 + 2 * k)) begin
               rdata_nxt  = cntr[k][31:0];
               shadow_nxt = cntr[k][CNTR_W-1:32];
            end
            if (addr_i == 6'(17 + 2 * k)) rdata_nxt = 32'(shadow);
            if (addr_i == 6'(48 + k))     rdata_nxt = 32'(evtsel[k]);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned k = 0; k < NUM_CNTR; k++) begin
            cntr[k]   <= '0;
            evtsel[k] <= 4'(k);
         end
         en       <= 1'b0;
         ovf      <= '0;
         mask     <= '0;
         shadow   <= '0;
         rdata_o  <= '0;
         rvalid_o <= 1'b0;
         irq_o    <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < NUM_CNTR; k++) cntr[k] <= cntr_nxt[k];
         // Select 0 belongs to the cycle counter and stays at its reset value.
         for (int unsigned k = 1; k < NUM_CNTR; k++) begin
            if (wr && addr_i == 6'(48 + k)) evtsel[k] <= wdata_i[3:0];
         end
         if (wr && addr_i == 6'h00) en   <= wdata_i[0];
         if (wr && addr_i == 6'h02) mask <= wdata_i[NUM_CNTR-1:0];
         ovf      <= ovf_nxt;
         shadow   <= shadow_nxt;
         rdata_o  <= rdata_nxt;
         rvalid_o <= rd;
         irq_o    <= |(ovf & mask);
      end
   end
endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: scenario tasks drive the MMIO port and compare
// read data popped from an expected-value queue; a NUM_EVT=8 copy checks out-of-range selects.
module tb_perf_counter_bank;
   logic        clk = 1'b0;
   logic        rst, halt, req, we;
   logic [5:0]  addr;
   logic [31:0] wdata, rdata, rdata8;
   logic [15:0] evt;
   logic        rvalid, irq, rvalid8, irq8;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb[$];
   logic [31:0] e;

   always #5 clk = ~clk;

   perf_counter_bank u_dut (
      .clk_i(clk), .rst_i(rst), .evt_i(evt), .halt_i(halt), .req_i(req), .we_i(we),
      .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .rvalid_o(rvalid), .irq_o(irq)
   );

   perf_counter_bank #(.NUM_EVT(8)) u_dut8 (
      .clk_i(clk), .rst_i(rst), .evt_i(evt[7:0]), .halt_i(halt), .req_i(req), .we_i(we),
      .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata8), .rvalid_o(rvalid8), .irq_o(irq8)
   );

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      req = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic [5:0] a, input logic [31:0] exp);
      req = 1'b1; we = 1'b0; addr = a;
      sb.push_back(exp);
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (rdata !== 32'd0 || rvalid !== 1'b0 || irq !== 1'b0) begin
         errors++; $display("FAIL reset_outputs: got rdata=%h rvalid=%b irq=%b want 0/0/0", rdata, rvalid, irq);
      end
      rst = 1'b0;
      rd(6'h00, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL reset_ctrl: got %h/%b want %h/1", rdata, rvalid, e); end
      rd(6'h01, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL reset_ovf: got %h/%b want %h/1", rdata, rvalid, e); end
      rd(6'h02, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL reset_mask: got %h/%b want %h/1", rdata, rvalid, e); end
      for (int k = 0; k < 8; k++) begin
         rd(6'(48 + k), 32'(k)); e = sb.pop_front(); checks++;
         if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL reset_evtsel%0d: got %h want %h", k, rdata, e); end
      end
      rd(6'h10, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL reset_cntr0: got %h want %h", rdata, e); end
      wr(6'h3F, 32'hFFFF_FFFF);
      rd(6'h3F, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL unmapped: got %h want %h", rdata, e); end
   endtask

   task automatic test_cycle_count();
      wr(6'h00, 32'd1);
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_after_write: got %b want 0", rvalid); end
      idle(10);
      rd(6'h10, 32'd10); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL cyc_lo: got %h/%b want %h/1", rdata, rvalid, e); end
      rd(6'h11, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL cyc_hi: got %h/%b want %h/1", rdata, rvalid, e); end
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_one_cycle: got %b want 0", rvalid); end
      wr(6'h00, 32'd0);
   endtask

   task automatic test_event_select();
      wr(6'h00, 32'd2); wr(6'h31, 32'd3); wr(6'h00, 32'd1);
      for (int i = 0; i < 5; i++) begin
         evt = 16'h0008 | ((i < 4) ? 16'h0004 : 16'h0000);
         @(negedge clk);
      end
      evt = '0;
      wr(6'h00, 32'd0);
      rd(6'h12, 32'd5); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL evt_cntr1: got %h want %h", rdata, e); end
      rd(6'h14, 32'd4); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL evt_cntr2: got %h want %h", rdata, e); end
      rd(6'h16, 32'd5); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL evt_cntr3: got %h want %h", rdata, e); end
      // select 15: in range for NUM_EVT=16, out of range for NUM_EVT=8 (evt[7] would alias)
      wr(6'h00, 32'd2); wr(6'h31, 32'd15); wr(6'h00, 32'd1);
      evt = 16'h8000; idle(3);
      evt = 16'h0080; idle(2);
      evt = '0;
      wr(6'h00, 32'd0);
      rd(6'h12, 32'd3); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL sel15_n16: got %h want %h", rdata, e); end
      checks++;
      if (rvalid8 !== 1'b1 || rdata8 !== 32'd0) begin errors++; $display("FAIL sel15_n8: got %h want 0", rdata8); end
      wr(6'h00, 32'd2); wr(6'h31, 32'd9); wr(6'h00, 32'd1);
      evt = 16'h0200; idle(2);
      evt = 16'h0002; idle(3);
      evt = '0;
      wr(6'h00, 32'd0);
      rd(6'h12, 32'd2); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL sel9_n16: got %h want %h", rdata, e); end
      checks++;
      if (rvalid8 !== 1'b1 || rdata8 !== 32'd0) begin errors++; $display("FAIL sel9_n8: got %h want 0", rdata8); end
   endtask

   task automatic test_overflow();
      wr(6'h00, 32'd2);
      wr(6'h14, 32'hFFFF_FFFF); wr(6'h15, 32'hFFFF_FFFF); wr(6'h32, 32'd0); wr(6'h02, 32'd4);
      wr(6'h00, 32'd1);
      evt = 16'h0001; @(negedge clk); evt = '0;
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_not_yet: got %b want 0", irq); end
      @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b want 1", irq); end
      wr(6'h00, 32'd0);
      rd(6'h01, 32'd4); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL ovf_flag: got %h want %h", rdata, e); end
      rd(6'h14, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL wrap_lo: got %h want %h", rdata, e); end
      rd(6'h15, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL wrap_hi: got %h want %h", rdata, e); end
      wr(6'h01, 32'd4);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold_w1c: got %b want 1", irq); end
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_deassert: got %b want 0", irq); end
      // W1C in the same cycle as a fresh overflow on that bit
      wr(6'h14, 32'hFFFF_FFFF); wr(6'h15, 32'hFFFF_FFFF); wr(6'h00, 32'd1);
      req = 1'b1; we = 1'b1; addr = 6'h01; wdata = 32'd4; evt = 16'h0001;
      @(negedge clk);
      req = 1'b0; we = 1'b0; evt = '0;
      wr(6'h00, 32'd0);
      rd(6'h01, 32'd4); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL ovf_w1c_race: got %h want %h", rdata, e); end
      wr(6'h02, 32'd0);
   endtask

   task automatic test_shadow();
      wr(6'h10, 32'hFFFF_FFFF); wr(6'h11, 32'd0);
      rd(6'h10, 32'hFFFF_FFFF); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL shadow_lo: got %h want %h", rdata, e); end
      wr(6'h00, 32'd1);
      idle(3);
      rd(6'h11, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL shadow_hi_stale: got %h want %h", rdata, e); end
      wr(6'h00, 32'd0);
      rd(6'h10, 32'd4); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL shadow_lo2: got %h want %h", rdata, e); end
      rd(6'h11, 32'd1); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL shadow_hi2: got %h want %h", rdata, e); end
   endtask

   task automatic test_write_priority();
      wr(6'h00, 32'd2); wr(6'h31, 32'd3); wr(6'h00, 32'd1);
      req = 1'b1; we = 1'b1; addr = 6'h12; wdata = 32'd100; evt = 16'h0008;
      @(negedge clk);
      req = 1'b0; we = 1'b0; evt = '0;
      wr(6'h00, 32'd0);
      rd(6'h12, 32'd100); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL write_beats_inc: got %h want %h", rdata, e); end
      rd(6'h16, 32'd1); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL neighbour_inc: got %h want %h", rdata, e); end
      wr(6'h00, 32'd1); wr(6'h00, 32'd3);
      rd(6'h00, 32'd1); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL clr_ctrl: got %h want %h", rdata, e); end
      rd(6'h01, 32'd4); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL clr_keeps_ovf: got %h want %h", rdata, e); end
      wr(6'h00, 32'd0);
      rd(6'h10, 32'd3); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL clr_cntr0: got %h want %h", rdata, e); end
      rd(6'h12, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL clr_cntr1: got %h want %h", rdata, e); end
      rd(6'h16, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL clr_cntr3: got %h want %h", rdata, e); end
   endtask

   task automatic test_halt();
      halt = 1'b1;
      wr(6'h00, 32'd3);
      evt = 16'hFFFF; idle(20); evt = '0;
      wr(6'h32, 32'd5);
      rd(6'h32, 32'd5); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL halt_regaccess: got %h want %h", rdata, e); end
      rd(6'h10, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL halt_cntr0: got %h want %h", rdata, e); end
      rd(6'h12, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL halt_cntr1: got %h want %h", rdata, e); end
      halt = 1'b0;
      idle(1);
      rd(6'h10, 32'd1); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL unhalt_cntr0: got %h want %h", rdata, e); end
   endtask

   task automatic test_reset_mid();
      wr(6'h02, 32'd4);
      idle(1);
      req = 1'b1; we = 1'b0; addr = 6'h10;
      @(posedge clk); #2;
      checks++;
      if (rvalid !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL pre_reset: got rvalid=%b irq=%b want 1/1", rvalid, irq); end
      rst = 1'b1; #1;
      checks++;
      if (rvalid !== 1'b0 || rdata !== 32'd0 || irq !== 1'b0) begin
         errors++; $display("FAIL mid_reset: got rdata=%h rvalid=%b irq=%b want 0/0/0", rdata, rvalid, irq);
      end
      req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      rd(6'h00, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL rst_ctrl: got %h want %h", rdata, e); end
      rd(6'h01, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL rst_ovf: got %h want %h", rdata, e); end
      rd(6'h02, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL rst_mask: got %h want %h", rdata, e); end
      rd(6'h31, 32'd1); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL rst_evtsel1: got %h want %h", rdata, e); end
      rd(6'h32, 32'd2); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL rst_evtsel2: got %h want %h", rdata, e); end
      rd(6'h10, 32'd0); e = sb.pop_front(); checks++;
      if (rvalid !== 1'b1 || rdata !== e) begin errors++; $display("FAIL rst_cntr0: got %h want %h", rdata, e); end
   endtask

   initial begin
      rst = 1'b1; halt = 1'b0; req = 1'b0; we = 1'b0;
      addr = '0; wdata = '0; evt = '0;
      test_reset();
      test_cycle_count();
      test_event_select();
      test_overflow();
      test_shadow();
      test_write_priority();
      test_halt();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
endmodule
